// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and helpers for the RC4 key search scheduler
package rc4_pkg;

  typedef enum logic [2:0] {IDLE, DISPATCH, RUN, FOUND, EXHAUSTED} sched_state_t;

  localparam int KEY_WIDTH = 24;

  typedef logic [KEY_WIDTH-1:0] key_t;

  // Index width never collapses to zero, so single-core builds still get a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idle_core_picker.sv
// rtl/idle_core_picker.sv - lowest-index priority encoder returning {valid, index}
module idle_core_picker
  import rc4_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] index
);

  // Walk from the top so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/key_search_scheduler.sv
// rtl/key_search_scheduler.sv - hands untried RC4 keys to idle crack cores, latches the first winner
module key_search_scheduler
  import rc4_pkg::*;
#(
  parameter int                   NUM_CORES = 4,
  parameter int                   KEY_WIDTH = rc4_pkg::KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] MAX_KEY   = 24'h3FFFFF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic [NUM_CORES-1:0]              core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0]    core_key,
  input  logic [NUM_CORES-1:0]              core_done,
  input  logic [NUM_CORES-1:0]              core_success,
  output logic                              stop,
  output logic                              busy,
  output logic                              found,
  output logic                              exhausted,
  output logic [KEY_WIDTH-1:0]              found_key,
  output logic [idx_width(NUM_CORES)-1:0]   found_core
);

  localparam int IW = idx_width(NUM_CORES);

  sched_state_t           state, state_n;
  logic [KEY_WIDTH:0]     next_key, next_key_n, max_ext;
  logic [NUM_CORES-1:0]   core_busy, busy_n, busy_eff, done_valid, succ_req, core_start_n;
  logic [KEY_WIDTH-1:0]   key_q [NUM_CORES];
  logic [KEY_WIDTH-1:0]   key_n [NUM_CORES];
  logic                   stop_n, found_n, exh_n, active, keys_left;
  logic [KEY_WIDTH-1:0]   found_key_n;
  logic [IW-1:0]          found_core_n, idle_idx, succ_idx;
  logic                   idle_valid, succ_valid;

  assign max_ext    = {1'b0, MAX_KEY};
  assign active     = (state == DISPATCH) || (state == RUN);
  assign busy       = active;
  assign keys_left  = (next_key <= max_ext);
  // A done from a core we never started is a protocol error and is dropped here.
  assign done_valid = core_done & core_busy;
  assign succ_req   = done_valid & core_success;
  assign busy_eff   = core_busy & ~done_valid;

  idle_core_picker #(.N(NUM_CORES), .IW(IW)) u_idle_pick (
    .req   (~busy_eff),
    .valid (idle_valid),
    .index (idle_idx)
  );

  idle_core_picker #(.N(NUM_CORES), .IW(IW)) u_succ_pick (
    .req   (succ_req),
    .valid (succ_valid),
    .index (succ_idx)
  );

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key_out
    assign core_key[g*KEY_WIDTH +: KEY_WIDTH] = key_q[g];
  end

  always_comb begin
    state_n      = state;
    next_key_n   = next_key;
    busy_n       = core_busy;
    core_start_n = '0;
    key_n        = key_q;
    stop_n       = stop;
    found_n      = found;
    exh_n        = exhausted;
    found_key_n  = found_key;
    found_core_n = found_core;

    if (start) begin
      // A restart from a live or finished search spends one cycle with stop high to flush the cores.
      state_n    = DISPATCH;
      next_key_n = '0;
      busy_n     = '0;
      stop_n     = (state != IDLE);
      found_n    = 1'b0;
      exh_n      = 1'b0;
    end else if (active) begin
      stop_n = 1'b0;
      busy_n = busy_eff;
      if (succ_valid) begin
        state_n      = FOUND;
        stop_n       = 1'b1;
        found_n      = 1'b1;
        found_key_n  = key_q[succ_idx];
        found_core_n = succ_idx;
      end else begin
        if ((state == DISPATCH) && idle_valid && keys_left) begin
          key_n[idle_idx]        = next_key[KEY_WIDTH-1:0];
          core_start_n[idle_idx] = 1'b1;
          busy_n[idle_idx]       = 1'b1;
          next_key_n             = next_key + 1'b1;
        end
        if ((next_key_n > max_ext) && (busy_n == '0)) begin
          state_n = EXHAUSTED;
          exh_n   = 1'b1;
        end else if ((|(~busy_n)) && (next_key_n <= max_ext)) begin
          state_n = DISPATCH;
        end else begin
          state_n = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      next_key   <= '0;
      core_busy  <= '0;
      core_start <= '0;
      stop       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      found_key  <= '0;
      found_core <= '0;
      for (int i = 0; i < NUM_CORES; i++) key_q[i] <= '0;
    end else begin
      state      <= state_n;
      next_key   <= next_key_n;
      core_busy  <= busy_n;
      core_start <= core_start_n;
      stop       <= stop_n;
      found      <= found_n;
      exhausted  <= exh_n;
      found_key  <= found_key_n;
      found_core <= found_core_n;
      for (int i = 0; i < NUM_CORES; i++) key_q[i] <= key_n[i];
    end
  end

endmodule
